// File: rtl/pseudo_spi_capture.sv
// Scan-chain readback engine: parallel-captures a scan chain, shifts it out with
// two-phase non-overlapping clocks and stores the bytes at descending SRAM addresses.
module pseudo_spi_capture #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int RESERVED_DATA_LEN = 8
) (
  input  logic                         CLK,
  input  logic                         rst_n,
  input  logic                         BGN,
  input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
  input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
  input  logic [7:0]                   FREQ_DIV,
  input  logic                         SPI_SI,
  output logic                         SCLK1,
  output logic                         SCLK2,
  output logic                         SEL,
  output logic                         CEN,
  output logic                         D_WE,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic [MEMORY_DATA_WIDTH-1:0] PO,
  output logic                         spi_is_done
);

  localparam int DW = MEMORY_DATA_WIDTH;
  localparam int AW = MEMORY_ADDR_WIDTH;
  localparam int RL = RESERVED_DATA_LEN;
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPT,
    ST_SHIFT,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [AW-1:0]   r_addr;
  logic [RL-1:0]   r_cnt;
  logic [7:0]      r_div_cfg;
  logic [7:0]      r_div;
  logic [1:0]      r_phase;
  logic [BW-1:0]   r_bit;
  logic [DW-1:0]   r_sr;

  logic            r_sclk1;
  logic            r_sclk2;
  logic            r_sel;
  logic            r_cen;
  logic            r_dwe;
  logic [AW-1:0]   r_a;
  logic [DW-1:0]   r_po;
  logic            r_done;

  logic            w_clocking;
  logic            w_phase_end;
  logic            w_step_end;
  logic            w_sample;
  logic            w_sclk1_next;
  logic            w_sclk2_next;
  logic            w_sel_next;
  logic            w_wr_next;
  logic            w_done_next;
  logic            w_start;

  // ---------------------------------------------------------------------------
  // Next-state and registered-output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_clocking   = 1'b0;
    w_phase_end  = 1'b0;
    w_step_end   = 1'b0;
    w_sample     = 1'b0;
    w_sclk1_next = 1'b0;
    w_sclk2_next = 1'b0;
    w_sel_next   = 1'b0;
    w_wr_next    = 1'b0;
    w_done_next  = 1'b0;
    w_start      = 1'b0;

    w_clocking  = (r_state == ST_CAPT) || (r_state == ST_SHIFT);
    w_phase_end = (r_div == r_div_cfg);
    w_step_end  = w_phase_end && (r_phase == 2'd3);

    case (r_state)
      ST_IDLE: begin
        if (BGN) begin
          w_state_next = ST_CAPT;
          w_start      = 1'b1;
        end
      end
      ST_CAPT: begin
        if (!BGN) begin
          w_state_next = ST_IDLE;
        end else if (w_step_end) begin
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!BGN) begin
          w_state_next = ST_IDLE;
        end else if (w_step_end && (r_bit == LAST_BIT)) begin
          w_state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!BGN) begin
          w_state_next = ST_IDLE;
        end else if (r_cnt == '0) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (!BGN) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Outputs are registered one cycle behind the state; gating with BGN makes
    // an abort drop the clocks, SEL and the write strobe on the same edge.
    w_sclk1_next = w_clocking && BGN && (r_phase == 2'd0);
    w_sclk2_next = w_clocking && BGN && (r_phase == 2'd2);
    w_sel_next   = (r_state == ST_CAPT) && BGN;
    w_wr_next    = (r_state == ST_WRITE) && BGN;
    w_done_next  = (r_state == ST_DONE) && BGN;
    w_sample     = (r_state == ST_SHIFT) && BGN && (r_phase == 2'd0) && (r_div == 8'd0);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration latch, phase/bit timing, deserialiser, byte/address counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_cnt     <= '0;
      r_div_cfg <= '0;
      r_div     <= '0;
      r_phase   <= '0;
      r_bit     <= '0;
      r_sr      <= '0;
    end else begin
      if (w_start) begin
        r_addr    <= ADDR_BGN;
        r_cnt     <= DATA_LEN;
        r_div_cfg <= FREQ_DIV;
        r_div     <= '0;
        r_phase   <= '0;
        r_bit     <= '0;
      end else if (w_clocking) begin
        if (w_phase_end) begin
          r_div   <= '0;
          r_phase <= r_phase + 2'd1;
          if ((r_state == ST_SHIFT) && (r_phase == 2'd3)) begin
            r_bit <= r_bit + BW'(1);
          end
        end else begin
          r_div <= r_div + 8'd1;
        end
      end

      // SO is stable during the first cycle of a step: the previous SCLK2
      // pulse has finished and this step's SCLK1 has not yet risen.
      if (w_sample) begin
        r_sr <= {SPI_SI, r_sr[DW-1:1]};
      end

      if ((r_state == ST_WRITE) && BGN && (r_cnt != '0)) begin
        r_addr <= r_addr - AW'(1);
        r_cnt  <= r_cnt - RL'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered chain and SRAM interface
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk1 <= 1'b0;
      r_sclk2 <= 1'b0;
      r_sel   <= 1'b0;
      r_cen   <= 1'b1;
      r_dwe   <= 1'b0;
      r_a     <= '0;
      r_po    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_sclk1 <= w_sclk1_next;
      r_sclk2 <= w_sclk2_next;
      r_sel   <= w_sel_next;
      r_cen   <= ~w_wr_next;
      r_dwe   <= w_wr_next;
      r_done  <= w_done_next;
      if (w_wr_next) begin
        r_a  <= r_addr;
        r_po <= r_sr;
      end
    end
  end

  assign SCLK1       = r_sclk1;
  assign SCLK2       = r_sclk2;
  assign SEL         = r_sel;
  assign CEN         = r_cen;
  assign D_WE        = r_dwe;
  assign A           = r_a;
  assign PO          = r_po;
  assign spi_is_done = r_done;

endmodule

// File: tb/tb_pseudo_spi_capture.sv
// Bench for pseudo_spi_capture: 14-cell two-phase scan chain model, SRAM write
// scoreboard, clock-shape monitor, latency, abort and reset scenarios.
module tb_pseudo_spi_capture;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       BGN;
  logic [8:0] ADDR_BGN;
  logic [7:0] DATA_LEN;
  logic [7:0] FREQ_DIV;
  logic       SPI_SI;
  logic       SCLK1;
  logic       SCLK2;
  logic       SEL;
  logic       CEN;
  logic       D_WE;
  logic [8:0] A;
  logic [7:0] PO;
  logic       spi_is_done;

  always #5 CLK = ~CLK;

  pseudo_spi_capture dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .BGN         (BGN),
    .ADDR_BGN    (ADDR_BGN),
    .DATA_LEN    (DATA_LEN),
    .FREQ_DIV    (FREQ_DIV),
    .SPI_SI      (SPI_SI),
    .SCLK1       (SCLK1),
    .SCLK2       (SCLK2),
    .SEL         (SEL),
    .CEN         (CEN),
    .D_WE        (D_WE),
    .A           (A),
    .PO          (PO),
    .spi_is_done (spi_is_done)
  );

  // Scan chain: master latch closes on SCLK1 fall, slave on SCLK2 fall; SIN=0.
  logic [13:0] r_pin;
  logic [13:0] r_mst;
  logic [13:0] r_slv;

  always @(negedge SCLK1) r_mst <= SEL ? r_pin : {r_slv[12:0], 1'b0};
  always @(negedge SCLK2) r_slv <= r_mst;
  assign SPI_SI = r_slv[13];

  typedef struct packed {
    logic [8:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests  = 0;
  int  n_fail   = 0;
  int  wr_count = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] stream_byte(input logic [13:0] pin, input int b);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      int s;
      s = 8 * b + k;
      r[k] = (s < 14) ? pin[13 - s] : 1'b0;
    end
    return r;
  endfunction

  // SRAM write scoreboard
  initial begin
    wr_t e;
    forever begin
      @(negedge CLK);
      if (rst_n === 1'b1 && (D_WE === 1'b1 || CEN === 1'b0)) begin
        check_val("we_cen", 32'(D_WE), 32'(!CEN));
        wr_count++;
        $display("[TB] write A=%0d PO=0x%02h", A, PO);
        if (exp_q.size() == 0) begin
          check_val("wr_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("wr_addr", 32'(A), 32'(e.a));
          check_val("wr_data", 32'(PO), 32'(e.d));
        end
      end
    end
  end

  // Clock-shape monitor
  bit mon_on   = 1'b0;
  int mdiv     = 0;
  int cyc      = 0;
  int ovl, bad_len, bad_gap, sel_len, sel_c1, p1, p2, len1, len2, last_fall;
  logic prev1, prev2;

  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (mon_on) begin
        if (SCLK1 && SCLK2) ovl++;
        if (SEL) sel_len++;
        if (SEL && SCLK1) sel_c1++;
        if ((SCLK1 && !prev1) || (SCLK2 && !prev2)) begin
          if (last_fall >= 0 && (cyc - last_fall) != mdiv + 1) bad_gap++;
        end
        if (SCLK1 && !prev1) p1++;
        if (SCLK2 && !prev2) p2++;
        if (SCLK1) len1++;
        else if (prev1) begin
          if (len1 != mdiv + 1) bad_len++;
          len1 = 0;
          last_fall = cyc;
        end
        if (SCLK2) len2++;
        else if (prev2) begin
          if (len2 != mdiv + 1) bad_len++;
          len2 = 0;
          last_fall = cyc;
        end
        prev1 = SCLK1;
        prev2 = SCLK2;
      end
    end
  end

  task automatic run_xfer(input logic [8:0] a, input logic [7:0] len, input logic [7:0] div,
                          input logic [13:0] pin, input bit auto_exp, input string tag);
    int  n;
    int  exp_lat;
    wr_t e;
    r_pin = pin;
    if (auto_exp) begin
      for (int b = 0; b <= int'(len); b++) begin
        e.a = a - 9'(b);
        e.d = stream_byte(pin, b);
        exp_q.push_back(e);
      end
    end
    @(negedge CLK);
    ADDR_BGN = a;
    DATA_LEN = len;
    FREQ_DIV = div;
    BGN      = 1'b1;
    @(posedge CLK);
    #1;
    ADDR_BGN = 9'($urandom);
    DATA_LEN = 8'($urandom);
    FREQ_DIV = 8'($urandom);
    exp_lat = 4 * (int'(div) + 1) * (1 + 8 * (int'(len) + 1)) + int'(len) + 2;
    n = 0;
    while (spi_is_done !== 1'b1 && n < 20000) begin
      @(posedge CLK);
      n++;
      #1;
    end
    $display("[TB] %s done after %0d cycles", tag, n);
    check_val({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check_val({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge CLK);
    BGN = 1'b0;
    @(posedge CLK);
    #1;
    check_val({tag, "_done_clr"}, 32'(spi_is_done), 32'd0);
  endtask

  function automatic logic [22:0] outs();
    return {SCLK1, SCLK2, SEL, CEN, D_WE, spi_is_done, A, PO};
  endfunction

  localparam logic [22:0] RST_OUTS = {6'b000100, 17'd0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [8:0]  adc;
    logic [13:0] pin;
    int          act;

    rst_n    = 1'b0;
    BGN      = 1'b1;
    ADDR_BGN = 9'd3;
    DATA_LEN = 8'd0;
    FREQ_DIV = 8'd0;
    r_pin    = '0;

    // 1: reset held with BGN=1
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check_val("rst_outs", 32'(outs()), 32'(RST_OUTS));
    end
    BGN   = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge CLK);

    // 2: ADC=510 chain readback
    adc = 9'd510;
    pin = '0;
    for (int j = 0; j < 9; j++) pin[13 - j] = adc[j];
    exp_q.push_back('{a: 9'd1, d: 8'hFE});
    exp_q.push_back('{a: 9'd0, d: 8'h01});
    run_xfer(9'd1, 8'd1, 8'd0, pin, 1'b0, "t2");

    // 3: FREQ_DIV=3 clock shape
    mdiv = 3; ovl = 0; bad_len = 0; bad_gap = 0; sel_len = 0; sel_c1 = 0;
    p1 = 0; p2 = 0; len1 = 0; len2 = 0; last_fall = -1; prev1 = 0; prev2 = 0;
    mon_on = 1'b1;
    run_xfer(9'h40, 8'd0, 8'd3, 14'($urandom), 1'b1, "t3");
    mon_on = 1'b0;
    check_val("t3_overlap", 32'(ovl), 32'd0);
    check_val("t3_hi_len", 32'(bad_len), 32'd0);
    check_val("t3_gap", 32'(bad_gap), 32'd0);
    check_val("t3_sel_len", 32'(sel_len), 32'd16);
    check_val("t3_sel_sclk1", 32'(sel_c1), 32'd4);
    check_val("t3_sclk1_cnt", 32'(p1), 32'd9);
    check_val("t3_sclk2_cnt", 32'(p2), 32'd9);

    // 4: address wrap 0 -> 511
    wr_count = 0;
    run_xfer(9'd0, 8'd1, 8'd1, 14'($urandom), 1'b1, "t4");
    check_val("t4_wr_count", 32'(wr_count), 32'd2);
    wr_count = 0;
    run_xfer(9'd300, 8'd3, 8'd2, 14'($urandom), 1'b1, "t4b");
    check_val("t4b_wr_count", 32'(wr_count), 32'd4);

    // 5: abort during bit 2 of byte 0
    wr_count = 0;
    r_pin = 14'($urandom);
    @(negedge CLK);
    ADDR_BGN = 9'd5; DATA_LEN = 8'd0; FREQ_DIV = 8'd0; BGN = 1'b1;
    @(posedge CLK);
    repeat (14) @(posedge CLK);
    @(negedge CLK);
    BGN = 1'b0;
    @(posedge CLK);
    #1;
    check_val("t5_abort_clk", 32'({SCLK1, SCLK2, SEL}), 32'd0);
    act = 0;
    repeat (60) begin
      @(negedge CLK);
      if (SCLK1 || SCLK2 || SEL || D_WE || spi_is_done) act++;
    end
    check_val("t5_idle_activity", 32'(act), 32'd0);
    check_val("t5_wr_count", 32'(wr_count), 32'd0);

    // 6: async reset mid-SHIFT, then a clean transfer
    r_pin = 14'($urandom);
    @(negedge CLK);
    ADDR_BGN = 9'd7; DATA_LEN = 8'd1; FREQ_DIV = 8'd0; BGN = 1'b1;
    @(posedge CLK);
    repeat (29) @(posedge CLK);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_outs", 32'(outs()), 32'(RST_OUTS));
    BGN = 1'b0;
    @(negedge CLK);
    rst_n = 1'b1;
    wr_count = 0;
    run_xfer(9'd7, 8'd1, 8'd0, 14'($urandom), 1'b1, "t6");
    check_val("t6_wr_count", 32'(wr_count), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
